rom_reader: RTL
===============

ROM_READER -- requirements
Module: rom_reader

Interface
REQ-001 SHALL have parameter DW, default 16, ROM data width.
REQ-002 SHALL have parameter AW, default 8, ROM address width.
REQ-003 SHALL have port clk  input  1  clock; all state on its rising edge.
REQ-004 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a burst; sampled only in IDLE.
REQ-006 SHALL have port base  input  AW  first ROM address, sampled with start.
REQ-007 SHALL have port len  input  AW+1  word count, 0..2**AW, sampled with start.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port rom_en  output  1  ROM read enable; drives the ROM en input.
REQ-011 SHALL have port rom_addr  output  AW  ROM read address.
REQ-012 SHALL have port rom_dout  input  DW  ROM registered read data, valid the cycle after rom_en.
REQ-013 SHALL have port out_valid  output  1  stream data valid.
REQ-014 SHALL have port out_ready  input  1  stream consumer ready.
REQ-015 SHALL have port out_data  output  DW  stream data.
REQ-016 SHALL have port out_last  output  1  marks final word of the burst.

Function
REQ-017 SHALL use states IDLE, READ, DRAIN: IDLE->READ on start with len>0; READ->DRAIN when the last read is issued; DRAIN->IDLE on the out_last handshake.
REQ-018 SHALL, on start with len=0, stay in IDLE, issue no reads, emit no stream words and pulse done the next cycle.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL assert rom_en only in READ, and only when remaining>0 and (buffer occupancy + in-flight reads) < 3.
REQ-021 SHALL drive rom_addr = base + issued count, modulo 2**AW, so addresses wrap from 2**AW-1 to 0.
REQ-022 SHALL set an in-flight flag on each issued read and push rom_dout into a 3-entry FIFO on the following edge; it SHALL never capture rom_dout otherwise.
REQ-023 SHALL present the FIFO head on out_data with out_valid=1 when non-empty; a word transfers when out_valid and out_ready are both high.
REQ-024 SHALL hold out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL assert out_last with the word whose count equals len.
REQ-026 SHALL allow push and pop in the same cycle without loss or overflow.
REQ-027 SHALL produce the first out_valid 3 cycles after the start edge, and 1 word/cycle thereafter while out_ready=1.
REQ-028 SHALL pulse done in the cycle after the out_last handshake, with busy=0 in that same cycle.
REQ-029 SHALL accept len=2**AW, reading every address exactly once.

Reset
REQ-030 SHALL, on nreset low, asynchronously force: state IDLE; busy, done, rom_en, out_valid and out_last 0; rom_addr 0; counters 0; FIFO empty; in-flight flag 0.
REQ-031 SHALL, on reset mid-burst, discard all buffered and in-flight data, and emit no further words or done for that burst.

Structure
REQ-032 SHALL place the state enum and the FIFO depth constant (3) in the shared package rom_reader_pkg.
REQ-033 SHALL implement the buffer as sub-module rom_reader_fifo (parameter DW, depth 3, push/pop/full/empty, async active-low reset).
REQ-034 SHALL contain no combinational path from out_ready to rom_en other than through the occupancy count.

Verification
REQ-035 SHALL be tested against the rom block with AW=8, DW=16, content mem[i]=i.
REQ-036 Scenario: base=0x10, len=4, out_ready=1 -> data 0x10,0x11,0x12,0x13 on cycles 3..6 after start, out_last on 0x13, done on cycle 7.
REQ-037 Scenario: base=0xFE, len=4 -> data 0xFE,0xFF,0x00,0x01 (address wrap).
REQ-038 Scenario: base=0, len=8, out_ready toggled 1-0 each cycle -> all 8 words in order, none dropped or duplicated, at most 3 reads outstanding.
REQ-039 Scenario: len=0 -> done pulse 1 cycle after start, no out_valid, no rom_en.
REQ-040 Scenario: nreset low during word 2 of len=16, then a new start base=0x40, len=2 -> only 0x40 and 0x41 emitted, with last on 0x41.
REQ-041 Scenario: start pulsed mid-burst -> ignored, and the original burst completes unchanged.

Source files
------------

// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM burst reader: controller states,
// stream buffer depth and the circular pointer helper used by the buffer.
package rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 3;
    localparam int FIFO_CNT_W = 2;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic logic [FIFO_CNT_W-1:0] ptr_inc(input logic [FIFO_CNT_W-1:0] p);
        return (p == FIFO_CNT_W'(FIFO_DEPTH - 1)) ? {FIFO_CNT_W{1'b0}} : p + {{(FIFO_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rom_reader_fifo.sv
// Three-entry stream buffer between the ROM read port and the output stream.
// Simultaneous push and pop is supported, including when full.
module rom_reader_fifo
    import rom_reader_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DW-1:0]         din,
    output logic [DW-1:0]         dout,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DW-1:0]         mem_r [FIFO_DEPTH];
    logic [FIFO_CNT_W-1:0] wr_ptr_r;
    logic [FIFO_CNT_W-1:0] rd_ptr_r;
    logic [FIFO_CNT_W-1:0] count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Qualify requests against occupancy.
    always_comb begin
        do_pop_s  = pop && (count_r != {FIFO_CNT_W{1'b0}});
        do_push_s = push && ((count_r != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_r <= {FIFO_CNT_W{1'b0}};
            rd_ptr_r <= {FIFO_CNT_W{1'b0}};
            count_r  <= {FIFO_CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(FIFO_CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(FIFO_CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty = (count_r == {FIFO_CNT_W{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/rom_reader.sv
// Burst reader: issues len sequential reads from a registered-output ROM
// starting at base and streams the words out with valid/ready and a last flag.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    state_t                state_r;
    state_t                state_s;
    logic [AW-1:0]         addr_r;
    logic [AW:0]           rd_rem_r;
    logic [AW:0]           out_rem_r;
    logic                  inflight_r;
    logic                  done_r;
    logic [FIFO_CNT_W-1:0] fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [2:0]            outstanding_s;
    logic                  issue_s;
    logic                  pop_s;
    logic                  last_s;
    logic                  start_ok_s;

    // Read issue depends only on registered occupancy, never on out_ready.
    always_comb begin
        outstanding_s = {1'b0, fifo_count_s} + {2'b00, inflight_r};
        issue_s       = (state_r == READ) && (rd_rem_r != {(AW+1){1'b0}}) &&
                        (outstanding_s < 3'd3) && !fifo_full_s;
        pop_s         = !fifo_empty_s && out_ready;
        last_s        = !fifo_empty_s && (out_rem_r == {{AW{1'b0}}, 1'b1});
        start_ok_s    = (state_r == IDLE) && start;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && (len != {(AW+1){1'b0}})) state_s = READ;
                else                                   state_s = IDLE;
            end
            READ: begin
                if (issue_s && (rd_rem_r == {{AW{1'b0}}, 1'b1})) state_s = DRAIN;
                else                                              state_s = READ;
            end
            DRAIN: begin
                if (pop_s && last_s) state_s = IDLE;
                else                 state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, address/remaining counters, in-flight flag and done pulse.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r    <= IDLE;
            addr_r     <= {AW{1'b0}};
            rd_rem_r   <= {(AW+1){1'b0}};
            out_rem_r  <= {(AW+1){1'b0}};
            inflight_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            inflight_r <= issue_s;
            done_r     <= (start_ok_s && (len == {(AW+1){1'b0}})) || (pop_s && last_s);
            if (start_ok_s) begin
                addr_r    <= base;
                rd_rem_r  <= len;
                out_rem_r <= len;
            end else begin
                if (issue_s) begin
                    addr_r   <= addr_r + {{(AW-1){1'b0}}, 1'b1};
                    rd_rem_r <= rd_rem_r - {{AW{1'b0}}, 1'b1};
                end
                if (pop_s) begin
                    out_rem_r <= out_rem_r - {{AW{1'b0}}, 1'b1};
                end
            end
        end
    end

    rom_reader_fifo #(
        .DW (DW)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (inflight_r),
        .pop    (pop_s),
        .din    (rom_dout),
        .dout   (out_data),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .count  (fifo_count_s)
    );

    assign busy      = (state_r != IDLE);
    assign done      = done_r;
    assign rom_en    = issue_s;
    assign rom_addr  = addr_r;
    assign out_valid = !fifo_empty_s;
    assign out_last  = last_s;

endmodule
